// File: rtl/count_pkg.sv
// Shared types for the count driver: FSM states and move direction.
package count_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

  localparam int CNT_W_DEF = 8;
  localparam int GAP_W_DEF = 4;

endpackage

// File: rtl/count_driver_if.sv
// Command/pulse bus between a controller (master) and the count driver (slave).
interface count_driver_if #(
  parameter int WIDTH = 8,
  parameter int GAP_W = 4
);
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_value;
  logic [GAP_W-1:0] gap;
  logic             abort;
  logic             clr;
  logic             inc;
  logic             dec;
  logic [WIDTH-1:0] shadow_count;
  logic             busy;
  logic             done;

  modport master (
    output tgt_valid, tgt_value, gap, abort, clr,
    input  tgt_ready, inc, dec, shadow_count, busy, done
  );

  modport slave (
    input  tgt_valid, tgt_value, gap, abort, clr,
    output tgt_ready, inc, dec, shadow_count, busy, done
  );
endinterface

// File: rtl/count_gap_timer.sv
// Loadable down-counter that paces the idle cycles between step pulses.
// Loaded with gap on entry to WAIT; expired is high in the last WAIT cycle,
// so WAIT lasts exactly the loaded number of cycles.
module count_gap_timer #(
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [GAP_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_expired
);

  logic [GAP_W-1:0] r_cnt;

  // Load takes priority; otherwise count down while enabled, saturating at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_cnt <= '0;
    else if (i_load)                      r_cnt <= i_load_val;
    else if (i_en && (r_cnt != '0))       r_cnt <= r_cnt - GAP_W'(1);
  end

  assign o_expired = (r_cnt <= GAP_W'(1));

endmodule

// File: rtl/count_driver.sv
// Drives inc/dec pulses into the downstream up/down counter until a shadow
// copy of that counter reaches the accepted target, then pulses done.
module count_driver
  import count_pkg::*;
#(
  parameter int WIDTH = CNT_W_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  count_driver_if.slave bus
);

  state_t           r_state, w_state_nxt;
  dir_t             r_dir, w_dir_nxt;
  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] r_shadow, w_shadow_nxt, w_step_val;
  logic [GAP_W-1:0] r_gap;
  logic             r_inc, r_dec, r_done;
  logic             w_inc_nxt, w_dec_nxt, w_done_nxt;
  logic             w_accept;
  logic             w_tmr_load, w_tmr_en, w_tmr_expired;

  // A handshake in a clr cycle is dropped, so clr masks the accept.
  assign w_accept   = bus.tgt_valid && (r_state == IDLE) && !bus.clr;
  // Shadow value after the pulse issued in the current STEP cycle.
  assign w_step_val = (r_dir == DIR_UP) ? r_shadow + WIDTH'(1) : r_shadow - WIDTH'(1);

  count_gap_timer #(.GAP_W(GAP_W)) u_gap_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (r_gap),
    .i_en       (w_tmr_en),
    .o_expired  (w_tmr_expired)
  );

  // Next-state, shadow update and registered-pulse decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_dir_nxt    = r_dir;
    w_shadow_nxt = r_shadow;
    w_done_nxt   = 1'b0;
    w_inc_nxt    = 1'b0;
    w_dec_nxt    = 1'b0;
    w_tmr_load   = 1'b0;
    w_tmr_en     = 1'b0;
    if (bus.clr) begin
      w_state_nxt  = IDLE;
      w_shadow_nxt = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (bus.tgt_value == r_shadow) begin
              w_done_nxt = 1'b1;
            end else begin
              w_state_nxt = STEP;
              w_dir_nxt   = (bus.tgt_value > r_shadow) ? DIR_UP : DIR_DN;
            end
          end
        end
        STEP: begin
          // The pulse in flight always lands, even when aborting.
          w_shadow_nxt = w_step_val;
          if (bus.abort) begin
            w_state_nxt = IDLE;
          end else if (w_step_val == r_target) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else if (r_gap == '0) begin
            w_state_nxt = STEP;
          end else begin
            w_state_nxt = WAIT;
            w_tmr_load  = 1'b1;
          end
        end
        WAIT: begin
          w_tmr_en = 1'b1;
          if (bus.abort)          w_state_nxt = IDLE;
          else if (w_tmr_expired) w_state_nxt = STEP;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
    if (w_state_nxt == STEP) begin
      w_inc_nxt = (w_dir_nxt == DIR_UP);
      w_dec_nxt = (w_dir_nxt == DIR_DN);
    end
  end

  // State, shadow and output pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_dir    <= DIR_UP;
      r_shadow <= '0;
      r_inc    <= 1'b0;
      r_dec    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_dir    <= w_dir_nxt;
      r_shadow <= w_shadow_nxt;
      r_inc    <= w_inc_nxt;
      r_dec    <= w_dec_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Target and gap are captured once per move at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target <= '0;
      r_gap    <= '0;
    end else if (w_accept) begin
      r_target <= bus.tgt_value;
      r_gap    <= bus.gap;
    end
  end

  assign bus.tgt_ready    = (r_state == IDLE);
  assign bus.busy         = (r_state != IDLE);
  assign bus.inc          = r_inc;
  assign bus.dec          = r_dec;
  assign bus.done         = r_done;
  assign bus.shadow_count = r_shadow;

endmodule

// File: doc/count_driver.md
Name: count_driver

Overview:
- Command-side companion to the team's up/down event counter. Accepts a target count over a valid/ready handshake and emits single-cycle inc or dec pulses, paced by a programmable gap, until a shadow copy of the counter equals the target. Then it pulses done.
- Sits upstream of the counter; its inc/dec outputs wire directly to the counter's inc/dec inputs.
- shadow_count tracks the downstream counter's value cycle-for-cycle when both come out of reset together.

Parameters:
- WIDTH, 8, width of target and shadow count; must match the downstream counter.
- GAP_W, 4, width of the inter-pulse gap field.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tgt_valid  in  1  target command valid.
- tgt_ready  out  1  block can accept a command; high only in IDLE.
- tgt_value  in  WIDTH  target count, unsigned.
- gap  in  GAP_W  idle cycles between consecutive pulses; sampled at accept.
- abort  in  1  cancel the move in progress.
- clr  in  1  synchronous clear: shadow_count to 0, move cancelled.
- inc  out  1  registered one-cycle increment pulse to the counter.
- dec  out  1  registered one-cycle decrement pulse to the counter.
- shadow_count  out  WIDTH  mirrored count value.
- busy  out  1  move in progress (state STEP or WAIT).
- done  out  1  one-cycle pulse on move completion.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; inc=dec=done=busy=0; shadow_count=0; tgt_ready=1 after release.
- States: IDLE, STEP, WAIT.
- IDLE:
  - tgt_ready=1.
  - Accept on the edge where tgt_valid & tgt_ready; latch target and gap.
  - If target == shadow_count: stay IDLE, done=1 next cycle, no pulse.
  - Else: go to STEP. Direction is UP if target > shadow_count, else DOWN, compared unsigned. Direction is fixed for the whole move.
- STEP (one cycle):
  - Exactly one of inc/dec is high.
  - shadow_count +/-1 at the end of that cycle, same edge at which the counter updates.
  - If the next shadow equals target: go to IDLE and assert done next cycle.
  - Else if gap==0: stay in STEP (back-to-back pulses).
  - Else: go to WAIT with the gap timer loaded with gap.
- WAIT:
  - inc=dec=0.
  - Timer decrements each cycle; enter STEP when it expires, after exactly gap idle cycles.
- Latency: accept at edge 0; first pulse in cycle 1. For N = |target-shadow| steps:
  - Last pulse in cycle 1+(N-1)(gap+1).
  - done in the following cycle.
  - tgt_ready is high in the done cycle; a new command may be accepted there.
- Arithmetic: linear stepping only, never wraps. A move from 250 to 3 issues 247 dec pulses. shadow_count never crosses 0 or 2^WIDTH-1.
- abort:
  - Sampled at the edge. If high in STEP or WAIT, next state is IDLE, no further pulses, no done.
  - A pulse already high in the abort cycle completes and is counted in shadow.
  - Ignored in IDLE.
- clr:
  - Highest priority after reset. Next cycle: shadow_count=0, state=IDLE, inc=dec=done=0, and any handshake in that cycle is dropped.
- Priority: rst_n > clr > abort > normal flow.
- Invariants: inc & dec never both high. done and inc/dec never high in the same cycle.

Decomposition:
- Shared package count_pkg:
  - state enum {IDLE, STEP, WAIT}.
  - direction enum {DIR_UP, DIR_DN}.
- One sub-module: count_gap_timer.
  - Loadable GAP_W down-counter with load, en, expired.
  - Async active-low reset on the same clk/rst_n.
- Integration check: instantiate the downstream counter in the bench; shadow_count must always equal its count.

Test Plan:
- Reset, then tgt_value=5, gap=0 → inc high in cycles 1–5 continuously, dec never; done in cycle 6; shadow_count=5; counter=5.
- From shadow=5, tgt_value=2, gap=2 → dec in cycles 1, 4, 7; done in cycle 8; shadow=2.
- tgt_value equal to shadow (2) → no pulses, done in cycle 1, tgt_ready stays high.
- From 0, tgt_value=10, gap=1; abort asserted during the cycle of the 4th pulse → 4 inc pulses total, no done, shadow=4, tgt_ready high the next cycle.
- From 250, tgt_value=3, gap=0 → 247 dec pulses, no wrap, done, shadow=3; inc & dec never both high.
- Mid-move clr, then rst_n pulsed low mid-move asynchronously → after clr: shadow=0, IDLE, no done. On the reset assertion: outputs go to reset values immediately without waiting for clk; first accept is legal the cycle after release.
